// File: rtl/adc_avg_pkg.sv
// Shared types and sizing helpers for the ADC moving-average filter.
// Holds the controller state encoding and the running-sum width rule.
package adc_avg_pkg;

    localparam int DEFAULT_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        READ   = 2'd2,
        UPDATE = 2'd3
    } avg_state_t;

    // Sum of 2^log2_depth samples of data_width bits never exceeds this width.
    function automatic int sum_width(input int data_width, input int log2_depth);
        return data_width + log2_depth;
    endfunction

endpackage

// File: rtl/adc_moving_average_if.sv
// Sample-in / average-out bundle of the moving-average filter.
// Master drives samples; slave (the filter) returns ready, averages and fill status.
interface adc_moving_average_if
    import adc_avg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample;
    logic                  sample_ready;
    logic                  avg_valid;
    logic [DATA_WIDTH-1:0] avg;
    logic                  filled;

    modport master (
        output sample_valid, sample,
        input  sample_ready, avg_valid, avg, filled
    );

    modport slave (
        input  sample_valid, sample,
        output sample_ready, avg_valid, avg, filled
    );
endinterface

// File: rtl/avg_sample_ram.sv
// Simple dual-port sample window store: one write port, one registered read port.
// Read data appears one cycle after the address; no reset so it maps onto block RAM.
module avg_sample_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/adc_moving_average.sv
// Boxcar average over the last 2^LOG2_DEPTH samples; avg lands 3 cycles after acceptance, ready only in IDLE.
// ADC_AVG_WARMUP_EN: hold back avg_valid until the window has been filled once.
module adc_moving_average
    import adc_avg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LOG2_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    adc_moving_average_if.slave  bus
);
    localparam int                  SUM_W    = sum_width(DATA_WIDTH, LOG2_DEPTH);
    localparam int                  DEPTH    = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);

    avg_state_t              r_state;
    avg_state_t              w_state_nxt;
    logic [LOG2_DEPTH-1:0]   r_wr_ptr;
    logic [LOG2_DEPTH-1:0]   r_clr_ptr;
    logic [LOG2_DEPTH:0]     r_fill_cnt;
    logic [LOG2_DEPTH:0]     w_fill_nxt;
    logic [SUM_W-1:0]        r_sum;
    logic [SUM_W-1:0]        w_sum_nxt;
    logic [DATA_WIDTH-1:0]   r_sample;
    logic [DATA_WIDTH-1:0]   r_avg;
    logic                    r_avg_valid;
    logic [DATA_WIDTH-1:0]   w_oldest;
    logic                    w_accept;
    logic                    w_pulse;
    logic                    w_ram_we;
    logic [LOG2_DEPTH-1:0]   w_ram_waddr;
    logic [DATA_WIDTH-1:0]   w_ram_wdata;

    assign w_accept   = bus.sample_valid && (r_state == IDLE);
    assign w_sum_nxt  = r_sum + SUM_W'(r_sample) - SUM_W'(w_oldest);
    assign w_fill_nxt = (r_fill_cnt == FULL_CNT) ? r_fill_cnt : r_fill_cnt + 1'b1;

`ifdef ADC_AVG_WARMUP_EN
    assign w_pulse = (w_fill_nxt == FULL_CNT);
`else
    assign w_pulse = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_waddr = r_wr_ptr;
        w_ram_wdata = r_sample;
        case (r_state)
            CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_ptr;
                w_ram_wdata = '0;
                if (r_clr_ptr == '1) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_state_nxt = UPDATE;
            end
            UPDATE: begin
                w_ram_we    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= '0;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_sum       <= '0;
            r_sample    <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_avg_valid <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clr_ptr  <= r_clr_ptr + 1'b1;
                    r_wr_ptr   <= '0;
                    r_fill_cnt <= '0;
                    r_sum      <= '0;
                    r_avg      <= '0;
                end
                IDLE: begin
                    if (w_accept) begin
                        r_sample <= bus.sample;
                    end
                end
                UPDATE: begin
                    // Pointer wraps naturally at the power-of-two window size.
                    r_sum       <= w_sum_nxt;
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    r_fill_cnt  <= w_fill_nxt;
                    r_avg       <= w_sum_nxt[SUM_W-1:LOG2_DEPTH];
                    r_avg_valid <= w_pulse;
                end
                default: ;
            endcase
        end
    end

    avg_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (LOG2_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_wr_ptr),
        .o_rdata (w_oldest)
    );

    assign bus.sample_ready = (r_state == IDLE);
    assign bus.avg_valid    = r_avg_valid;
    assign bus.avg          = r_avg;
    assign bus.filled       = (r_fill_cnt == FULL_CNT);
endmodule

// File: tb/tb_adc_moving_average.sv
// Directed bench for adc_moving_average with a 4-sample window.
// Expected averages are hand-computed; ADC_AVG_WARMUP_EN selects the pulse expectations.
module tb_adc_moving_average;
    localparam int DW = 12;
    localparam int L2 = 2;

`ifdef ADC_AVG_WARMUP_EN
    localparam bit WARMUP = 1'b1;
`else
    localparam bit WARMUP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    adc_moving_average_if #(.DATA_WIDTH(DW)) bus ();

    adc_moving_average #(
        .DATA_WIDTH (DW),
        .LOG2_DEPTH (L2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample in an IDLE cycle and return at T+3; early flags any pulse at T+1/T+2.
    task automatic push(input logic [DW-1:0] x, output bit early);
        early            = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample       = x;
        step();
        bus.sample_valid = 1'b0;
        early            = early | bus.avg_valid;
        step();
        early            = early | bus.avg_valid;
        step();
    endtask

    task automatic test_reset();
        logic exp_rdy;
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        step();
        step();
        n_checks += 4;
        if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.sample_ready); end
        if (bus.avg_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_avg_valid: got %b expected 0", bus.avg_valid); end
        if (bus.avg !== 12'd0)         begin n_fail++; $display("FAIL reset_avg: got %0d expected 0", bus.avg); end
        if (bus.filled !== 1'b0)       begin n_fail++; $display("FAIL reset_filled: got %b expected 0", bus.filled); end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_rdy = (k == 4);
            n_checks++;
            if (bus.sample_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL clear_ready[%0d]: got %b expected %b", k, bus.sample_ready, exp_rdy);
            end
            if (k < 4) begin
                n_checks += 3;
                if (bus.avg !== 12'd0)      begin n_fail++; $display("FAIL clear_avg[%0d]: got %0d expected 0", k, bus.avg); end
                if (bus.avg_valid !== 1'b0) begin n_fail++; $display("FAIL clear_avg_valid[%0d]: got %b expected 0", k, bus.avg_valid); end
                if (bus.filled !== 1'b0)    begin n_fail++; $display("FAIL clear_filled[%0d]: got %b expected 0", k, bus.filled); end
            end
        end
    endtask

    task automatic test_ramp();
        int   vin  [4];
        int   vexp [4];
        bit   early;
        logic exp_vld;
        logic exp_fill;
        vin  = '{100, 200, 300, 400};
        vexp = '{25, 75, 150, 250};
        for (int i = 0; i < 4; i++) begin
            push(DW'(vin[i]), early);
            exp_vld  = !WARMUP || (i == 3);
            exp_fill = (i == 3);
            n_checks += 5;
            if (early !== 1'b0)            begin n_fail++; $display("FAIL ramp_early_pulse[%0d]: got %b expected 0", i, early); end
            if (bus.avg_valid !== exp_vld) begin n_fail++; $display("FAIL ramp_avg_valid[%0d]: got %b expected %b", i, bus.avg_valid, exp_vld); end
            if (bus.avg !== DW'(vexp[i]))  begin n_fail++; $display("FAIL ramp_avg[%0d]: got %0d expected %0d", i, bus.avg, vexp[i]); end
            if (bus.filled !== exp_fill)   begin n_fail++; $display("FAIL ramp_filled[%0d]: got %b expected %b", i, bus.filled, exp_fill); end
            if (bus.sample_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_ready[%0d]: got %b expected 1", i, bus.sample_ready); end
        end
    endtask

    task automatic test_wrap();
        int vexp [4];
        bit early;
        vexp = '{1323, 2272, 3196, 4095};
        push(12'd500, early);
        n_checks += 3;
        if (bus.avg_valid !== 1'b1)  begin n_fail++; $display("FAIL wrap_avg_valid: got %b expected 1", bus.avg_valid); end
        if (bus.avg !== 12'd350)     begin n_fail++; $display("FAIL wrap_avg: got %0d expected 350", bus.avg); end
        if (dut.r_wr_ptr !== 2'd1)   begin n_fail++; $display("FAIL wrap_wr_ptr: got %0d expected 1", dut.r_wr_ptr); end
        for (int i = 0; i < 4; i++) begin
            push(12'hFFF, early);
            n_checks += 2;
            if (bus.avg_valid !== 1'b1)   begin n_fail++; $display("FAIL full_avg_valid[%0d]: got %b expected 1", i, bus.avg_valid); end
            if (bus.avg !== DW'(vexp[i])) begin n_fail++; $display("FAIL full_avg[%0d]: got %0d expected %0d", i, bus.avg, vexp[i]); end
        end
    endtask

    // Valid held high with data 1000+7c: only cycles 0,3,6,9 are IDLE and get accepted.
    task automatic test_drop();
        int   vexp [4];
        logic exp_rdy;
        logic exp_vld;
        vexp = '{3321, 2552, 1789, 1031};
        for (int c = 0; c < 12; c++) begin
            exp_rdy = ((c % 3) == 0);
            n_checks++;
            if (bus.sample_ready !== exp_rdy) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b expected %b", c, bus.sample_ready, exp_rdy); end
            if (c > 0) begin
                exp_vld = ((c % 3) == 0);
                n_checks++;
                if (bus.avg_valid !== exp_vld) begin n_fail++; $display("FAIL drop_avg_valid[%0d]: got %b expected %b", c, bus.avg_valid, exp_vld); end
                if (exp_vld) begin
                    n_checks++;
                    if (bus.avg !== DW'(vexp[c/3-1])) begin n_fail++; $display("FAIL drop_avg[%0d]: got %0d expected %0d", c, bus.avg, vexp[c/3-1]); end
                end
            end
            bus.sample_valid = 1'b1;
            bus.sample       = DW'(1000 + 7 * c);
            step();
        end
        bus.sample_valid = 1'b0;
        n_checks += 2;
        if (bus.avg_valid !== 1'b1) begin n_fail++; $display("FAIL drop_last_valid: got %b expected 1", bus.avg_valid); end
        if (bus.avg !== DW'(vexp[3])) begin n_fail++; $display("FAIL drop_last_avg: got %0d expected %0d", bus.avg, vexp[3]); end
    endtask

    task automatic test_mid_reset();
        bit   early;
        logic exp_rdy;
        logic exp_vld;
        bus.sample_valid = 1'b1;
        bus.sample       = 12'd777;
        step();
        bus.sample_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        n_checks += 4;
        if (bus.avg !== 12'd0)         begin n_fail++; $display("FAIL mid_reset_avg: got %0d expected 0", bus.avg); end
        if (bus.avg_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_reset_avg_valid: got %b expected 0", bus.avg_valid); end
        if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", bus.sample_ready); end
        if (bus.filled !== 1'b0)       begin n_fail++; $display("FAIL mid_reset_filled: got %b expected 0", bus.filled); end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_rdy = (k == 4);
            n_checks++;
            if (bus.sample_ready !== exp_rdy) begin n_fail++; $display("FAIL reclear_ready[%0d]: got %b expected %b", k, bus.sample_ready, exp_rdy); end
        end
        push(12'd40, early);
        exp_vld = !WARMUP;
        n_checks += 3;
        if (early !== 1'b0)            begin n_fail++; $display("FAIL post_reset_early: got %b expected 0", early); end
        if (bus.avg_valid !== exp_vld) begin n_fail++; $display("FAIL post_reset_avg_valid: got %b expected %b", bus.avg_valid, exp_vld); end
        if (bus.avg !== 12'd10)        begin n_fail++; $display("FAIL post_reset_avg: got %0d expected 10", bus.avg); end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        test_reset();
        test_ramp();
        test_wrap();
        test_drop();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end
endmodule
